// File: rtl/regfile_wb_ctrl_if.sv
// rtl/regfile_wb_ctrl_if.sv - write-back requester, register-file write port and issue/scoreboard bundle
interface regfile_wb_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                   req0_valid;
  logic [ADDR_W-1:0]      req0_rd;
  logic [DATA_W-1:0]      req0_data;
  logic                   req0_ready;

  logic                   req1_valid;
  logic [ADDR_W-1:0]      req1_rd;
  logic [DATA_W-1:0]      req1_data;
  logic                   req1_ready;

  logic                   WR;
  logic [ADDR_W-1:0]      RW;
  logic [DATA_W-1:0]      DW;

  logic                   iss_valid;
  logic [ADDR_W-1:0]      iss_ra;
  logic                   iss_ra_en;
  logic [ADDR_W-1:0]      iss_rb;
  logic                   iss_rb_en;
  logic [ADDR_W-1:0]      iss_rd;
  logic                   iss_rd_en;
  logic                   stall;
  logic [2**ADDR_W-1:0]   busy;

  // master: pipeline side (requesters, issue stage, register file)
  modport master (
    output req0_valid, req0_rd, req0_data,
    input  req0_ready,
    output req1_valid, req1_rd, req1_data,
    input  req1_ready,
    input  WR, RW, DW,
    output iss_valid, iss_ra, iss_ra_en, iss_rb, iss_rb_en, iss_rd, iss_rd_en,
    input  stall, busy
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    output req0_ready,
    input  req1_valid, req1_rd, req1_data,
    output req1_ready,
    output WR, RW, DW,
    input  iss_valid, iss_ra, iss_ra_en, iss_rb, iss_rb_en, iss_rd, iss_rd_en,
    output stall, busy
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - round-robin write-back arbiter and busy scoreboard for the 32x32 register file
module regfile_wb_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  regfile_wb_ctrl_if.slave bus
);
  localparam int NREG = 2**ADDR_W;

  logic              rr_ptr_q, rr_ptr_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] dw_q, dw_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic grant0, grant1, stall_c, fire;

  always_comb begin
    // rr_ptr only matters on a tie; it names the requester that lost last time
    grant0 = bus.req0_valid & (~bus.req1_valid | ~rr_ptr_q);
    grant1 = bus.req1_valid & (~bus.req0_valid |  rr_ptr_q);

    rr_ptr_d = rr_ptr_q;
    wr_d     = 1'b0;
    rw_d     = rw_q;
    dw_d     = dw_q;
    if (grant0) begin
      rr_ptr_d = 1'b1;
      wr_d     = (bus.req0_rd != '0);
      rw_d     = bus.req0_rd;
      dw_d     = bus.req0_data;
    end else if (grant1) begin
      rr_ptr_d = 1'b0;
      wr_d     = (bus.req1_rd != '0);
      rw_d     = bus.req1_rd;
      dw_d     = bus.req1_data;
    end

    stall_c = bus.iss_valid & ((bus.iss_ra_en & busy_q[bus.iss_ra]) |
                               (bus.iss_rb_en & busy_q[bus.iss_rb]) |
                               (bus.iss_rd_en & busy_q[bus.iss_rd]));
    fire    = bus.iss_valid & ~stall_c;

    // Clear on commit first so a same-edge reservation of the register wins
    busy_d = busy_q;
    if (wr_q) begin
      busy_d[rw_q] = 1'b0;
    end
    if (fire & bus.iss_rd_en & (bus.iss_rd != '0)) begin
      busy_d[bus.iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rr_ptr_q <= 1'b0;
      wr_q     <= 1'b0;
      rw_q     <= '0;
      dw_q     <= '0;
      busy_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_q     <= wr_d;
      rw_q     <= rw_d;
      dw_q     <= dw_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.WR         = wr_q;
  assign bus.RW         = rw_q;
  assign bus.DW         = dw_q;
  assign bus.stall      = stall_c;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - randomized and directed bench for regfile_wb_ctrl against a behavioural model
module tb_regfile_wb_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  regfile_wb_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: set of pending registers, who wins the next tie, and the write now on the port
  bit [31:0] m_busy;
  int        m_prefer;
  bit        m_wr;
  bit [4:0]  m_rw;
  bit [31:0] m_dw;
  bit        m_g0, m_g1, m_stall;

  function automatic void model_reset();
    m_busy = '0; m_prefer = 0; m_wr = 0; m_rw = '0; m_dw = '0;
  endfunction

  function automatic bit pending(bit en, bit [4:0] idx);
    return en && (idx != 0) && m_busy[idx];
  endfunction

  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic step();
    bit fire;
    #1;
    if (!HRESETn) model_reset();
    m_g0    = bus.req0_valid && (!bus.req1_valid || m_prefer == 0);
    m_g1    = bus.req1_valid && !m_g0;
    m_stall = bus.iss_valid && (pending(bus.iss_ra_en, bus.iss_ra) ||
                                pending(bus.iss_rb_en, bus.iss_rb) ||
                                pending(bus.iss_rd_en, bus.iss_rd));
    check_eq("req0_ready", 32'(bus.req0_ready), 32'(m_g0));
    check_eq("req1_ready", 32'(bus.req1_ready), 32'(m_g1));
    check_eq("stall",      32'(bus.stall),      32'(m_stall));
    if (HRESETn) begin
      if (m_wr) m_busy[m_rw] = 1'b0;
      fire = bus.iss_valid && !m_stall;
      if (fire && bus.iss_rd_en && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
      if (m_g0 || m_g1) begin
        m_prefer = m_g0 ? 1 : 0;
        m_rw     = m_g0 ? bus.req0_rd   : bus.req1_rd;
        m_dw     = m_g0 ? bus.req0_data : bus.req1_data;
        m_wr     = (m_rw != 0);
      end else begin
        m_wr = 1'b0;
      end
    end
    @(negedge HCLK);
    check_eq("WR",   32'(bus.WR), 32'(m_wr));
    check_eq("RW",   32'(bus.RW), 32'(m_rw));
    check_eq("DW",   bus.DW,      m_dw);
    check_eq("busy", bus.busy,    m_busy);
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_rd = '0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_rd = '0; bus.req1_data = '0;
    bus.iss_valid = 0; bus.iss_ra = '0; bus.iss_ra_en = 0;
    bus.iss_rb = '0; bus.iss_rb_en = 0; bus.iss_rd = '0; bus.iss_rd_en = 0;
  endtask

  function automatic bit [4:0] pick_rd();
    for (int k = 0; k < 4; k++) begin
      bit [4:0] r = 5'($urandom_range(0, 7));
      if (m_busy[r]) return r;
    end
    return 5'($urandom_range(0, 7));
  endfunction

  bit [4:0] wr_seq[$];
  bit [4:0] exp_seq[8];

  initial begin
    int i0, i1;
    idle_inputs();
    model_reset();
    HRESETn = 1'b0;
    bus.req0_valid = 1; bus.req0_rd = 5'd1; bus.req0_data = 32'h1111_0001;
    bus.req1_valid = 1; bus.req1_rd = 5'd2; bus.req1_data = 32'h2222_0002;
    bus.iss_valid = 1; bus.iss_ra = 5'd3; bus.iss_ra_en = 1;
    @(negedge HCLK);
    step();
    step();
    bus.iss_valid = 0;
    HRESETn = 1'b1;

    // Dual contention straight after reset: req0 must win first
    i0 = 0; i1 = 0;
    for (int c = 0; c < 20 && (i0 < 4 || i1 < 4); c++) begin
      bus.req0_valid = (i0 < 4); bus.req0_rd = 5'(1 + i0); bus.req0_data = 32'hA000_0000 | 32'(1 + i0);
      bus.req1_valid = (i1 < 4); bus.req1_rd = 5'(9 + i1); bus.req1_data = 32'hB000_0000 | 32'(9 + i1);
      step();
      if (bus.WR) wr_seq.push_back(bus.RW);
      if (m_g0) i0++;
      if (m_g1) i1++;
    end
    exp_seq = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};
    check_eq("dual_count", 32'(wr_seq.size()), 32'd8);
    for (int k = 0; k < 8 && k < wr_seq.size(); k++) check_eq("dual_order", 32'(wr_seq[k]), 32'(exp_seq[k]));
    idle_inputs();
    step();

    // Single write then the port must go quiet
    bus.req0_valid = 1; bus.req0_rd = 5'd3; bus.req0_data = 32'hDEAD_BEEF;
    step();
    check_eq("single_wr", 32'(bus.WR), 32'd1);
    idle_inputs();
    step();
    check_eq("single_wr_drop", 32'(bus.WR), 32'd0);

    // Write to r0 is accepted but never reaches the register file
    bus.req1_valid = 1; bus.req1_rd = 5'd0; bus.req1_data = 32'h1234_5678;
    step();
    check_eq("r0_no_wr", 32'(bus.WR), 32'd0);
    idle_inputs();
    step();

    // RAW on r5: reserve, stall, write back, release two edges after accept
    bus.iss_valid = 1; bus.iss_rd = 5'd5; bus.iss_rd_en = 1;
    step();
    bus.iss_rd_en = 0; bus.iss_ra = 5'd5; bus.iss_ra_en = 1;
    bus.req0_valid = 1; bus.req0_rd = 5'd5; bus.req0_data = 32'h0000_0555;
    step();
    bus.req0_valid = 0;
    step();
    #1;
    check_eq("raw_release", 32'(bus.stall), 32'd0);
    step();
    idle_inputs();
    step();

    // Randomized traffic on a small register window to provoke hazards
    for (int c = 0; c < 400; c++) begin
      if (!bus.req0_valid || m_g0) begin
        bus.req0_valid = 1'($urandom_range(0, 1)); bus.req0_rd = pick_rd(); bus.req0_data = $urandom;
      end
      if (!bus.req1_valid || m_g1) begin
        bus.req1_valid = 1'($urandom_range(0, 1)); bus.req1_rd = pick_rd(); bus.req1_data = $urandom;
      end
      if (!m_stall || $urandom_range(0, 3) == 0) begin
        bus.iss_valid = ($urandom_range(0, 9) < 7);
        bus.iss_ra = 5'($urandom_range(0, 7)); bus.iss_ra_en = 1'($urandom_range(0, 1));
        bus.iss_rb = 5'($urandom_range(0, 7)); bus.iss_rb_en = 1'($urandom_range(0, 1));
        bus.iss_rd = 5'($urandom_range(0, 7)); bus.iss_rd_en = 1'($urandom_range(0, 1));
      end
      step();
    end

    // Asynchronous reset while r7 is in flight
    idle_inputs();
    HRESETn = 1'b0;
    step();
    HRESETn = 1'b1;
    bus.iss_valid = 1; bus.iss_rd = 5'd7; bus.iss_rd_en = 1;
    step();
    idle_inputs();
    bus.req0_valid = 1; bus.req0_rd = 5'd7; bus.req0_data = 32'h7777_7777;
    step();
    check_eq("pre_rst_wr",   32'(bus.WR),      32'd1);
    check_eq("pre_rst_busy", 32'(bus.busy[7]), 32'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    check_eq("async_rst_wr",   32'(bus.WR), 32'd0);
    check_eq("async_rst_busy", bus.busy,    32'd0);
    model_reset();
    idle_inputs();
    @(negedge HCLK);
    step();
    HRESETn = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-back controller for the 32x32 two-read/one-write register file.
- Shares the single write port (WR/RW/DW) between two write-back requesters (req0 = ALU, req1 = load unit) with round-robin arbitration.
- Keeps a busy-register scoreboard that stalls issue on RAW/WAW hazards until the pending write has committed.
- Sits between the issue/execute stages and the register file; drives the register file's write port directly.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width; register count = 2**ADDR_W; register 0 is hard-wired zero.

Ports:
- HCLK  input  1  system clock, all state on rising edge
- HRESETn  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has a write-back
- req0_rd  input  ADDR_W  requester 0 destination
- req0_data  input  DATA_W  requester 0 data
- req0_ready  output  1  requester 0 accepted this cycle
- req1_valid  input  1  requester 1 has a write-back
- req1_rd  input  ADDR_W  requester 1 destination
- req1_data  input  DATA_W  requester 1 data
- req1_ready  output  1  requester 1 accepted this cycle
- WR  output  1  register file write enable (registered)
- RW  output  ADDR_W  register file write index (registered)
- DW  output  DATA_W  register file write data (registered)
- iss_valid  input  1  issue stage presents an instruction
- iss_ra  input  ADDR_W  source A index
- iss_ra_en  input  1  source A is used
- iss_rb  input  ADDR_W  source B index
- iss_rb_en  input  1  source B is used
- iss_rd  input  ADDR_W  destination to reserve
- iss_rd_en  input  1  instruction writes a destination
- stall  output  1  issue must hold
- busy  output  2**ADDR_W  scoreboard vector, bit i = register i pending

Behaviour:
- Reset (HRESETn low, asynchronous): WR=0, RW=0, DW=0, busy=0, rr_ptr=0 (req0 preferred). While held, stall is 0 because busy is 0.
- Arbitration is combinational within the cycle:
  - only req0_valid: req0_ready=1.
  - only req1_valid: req1_ready=1.
  - both valid: the requester selected by rr_ptr gets ready.
  - at most one ready is high per cycle; ready is never high without the matching valid.
- Accept = valid & ready.
  - On an accepted edge rr_ptr <= index of the loser (the other requester).
  - With no accept, rr_ptr holds.
  - Sustained dual requests therefore alternate 0,1,0,1.
- Write-port latency is 1 cycle. On the accept edge:
  - WR <= (rd != 0), RW <= rd, DW <= data.
  - With no accept, WR <= 0 and RW/DW hold their last values.
  - A write to r0 is accepted (ready=1) but produces WR=0.
- Commit: the register file samples on the edge after accept. Commit is defined as WR=1 at a rising edge; at that edge busy[RW] <= 0.
- Issue fire: iss_fire = iss_valid & ~stall.
  - On a fire edge with iss_rd_en and iss_rd != 0, busy[iss_rd] <= 1.
  - busy[0] is constantly 0.
- stall = iss_valid & ((iss_ra_en & busy[iss_ra]) | (iss_rb_en & busy[iss_rb]) | (iss_rd_en & busy[iss_rd])).
  - stall is combinational on the current busy vector.
  - WAW is covered by the iss_rd term.
  - Indices equal to 0 never stall.
- Simultaneous set and clear of the same register on one edge: set wins, busy stays 1. This case cannot normally arise because the iss_rd term stalls it; it is required for robustness.
- A register is readable with correct data from the cycle after its busy bit clears: the commit edge writes both the register file and the scoreboard.
- No buffering: a requester not granted holds valid, rd and data stable until ready.
- Reset mid-operation: WR drops immediately, the in-flight write is lost, and all busy bits clear.

Test Plan:
- Reset: HRESETn=0 with both requesters valid -> WR=0, busy=0, stall=0, both ready signals follow arbitration (req0 preferred); after release the first dual-request grant goes to req0.
- Single write: req0 rd=3, data=0xDEADBEEF for 1 cycle -> req0_ready=1 that cycle; next cycle WR=1, RW=3, DW=0xDEADBEEF for exactly one cycle; then WR=0.
- Dual contention: req0 (rd=1..4) and req1 (rd=9..12) valid for 8 cycles -> grants alternate req0,req1,... and the WR sequence is RW=1,9,2,10,3,11,4,12 with matching data and no gaps.
- r0 write: req1 rd=0, data=0x12345678 -> req1_ready=1, WR stays 0, busy unchanged.
- RAW stall: issue with rd=5 fires (busy[5]=1), next issue has ra=5 -> stall=1; req0 writes rd=5, accepted at cycle t -> WR=1 during t+1, busy[5]=0 and stall=0 from t+2.
- Async reset mid-write: HRESETn low while WR=1 and busy[7]=1 -> WR=0 and busy=0 immediately, without waiting for HCLK.
